// File: rtl/cpu_bus_defs.sv
// Shared bus widths, arbiter state encodings and grant codes for the CPU memory arbiter.
// The state encoding is chosen so that a grant state's value equals its one-hot grant code.
package cpu_bus_defs;

   localparam int WB_AW = 32;
   localparam int WB_DW = 16;
   localparam int WB_SW = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GNT_I = 2'b01,
      ST_GNT_D = 2'b10
   } arb_state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_I    = 2'b01;
   localparam logic [1:0] GNT_D    = 2'b10;

   localparam logic LAST_I = 1'b0;
   localparam logic LAST_D = 1'b1;

   // Pick the next grant from IDLE; round-robin hands a tie to whoever did not go last.
   function automatic arb_state_t arb_pick(input logic im_req, input logic dm_req,
                                           input logic last_gnt, input logic data_prio);
      arb_state_t pick;
      pick = ST_IDLE;
      if (im_req && dm_req)
         pick = (data_prio || (last_gnt == LAST_I)) ? ST_GNT_D : ST_GNT_I;
      else if (dm_req)
         pick = ST_GNT_D;
      else if (im_req)
         pick = ST_GNT_I;
      return pick;
   endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts strobed cycles without a slave response and flags the one that
// reaches TIMEOUT-1, so a hung slave cycle can be failed back to its master.
module wb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic count_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_cnt;

   assign expired_o = count_i && (r_cnt == LAST_CNT);

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i || expired_o)
         r_cnt <= '0;
      else if (count_i)
         r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one Wishbone classic port between the icache refill master and the data master:
// grant FSM, slave-side output mux, ack/err steering and hung-cycle watchdog.
module cpu_mem_arbiter
   import cpu_bus_defs::*;
#(
   parameter int TIMEOUT       = 255,
   parameter int DATA_PRIORITY = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WB_AW-1:0] im_adr_i,
   input  logic [WB_SW-1:0] im_sel_i,
   input  logic             im_cyc_i,
   input  logic             im_stb_i,
   output logic [WB_DW-1:0] im_dat_o,
   output logic             im_ack_o,
   output logic             im_err_o,
   input  logic [WB_AW-1:0] dm_adr_i,
   input  logic [WB_DW-1:0] dm_dat_i,
   input  logic [WB_SW-1:0] dm_sel_i,
   input  logic             dm_we_i,
   input  logic             dm_cyc_i,
   input  logic             dm_stb_i,
   output logic [WB_DW-1:0] dm_dat_o,
   output logic             dm_ack_o,
   output logic             dm_err_o,
   output logic [WB_AW-1:0] wb_adr_o,
   output logic [WB_DW-1:0] wb_dat_o,
   output logic [WB_SW-1:0] wb_sel_o,
   output logic             wb_we_o,
   output logic             wb_cyc_o,
   output logic             wb_stb_o,
   input  logic [WB_DW-1:0] wb_dat_i,
   input  logic             wb_ack_i,
   input  logic             wb_err_i,
   output logic [1:0]       gnt_o
);

   arb_state_t r_state;
   arb_state_t w_state_next;
   logic       r_last_gnt;
   logic       w_last_gnt_next;

   logic w_im_req;
   logic w_dm_req;
   logic w_sel_i;
   logic w_sel_d;
   logic w_mst_cyc;
   logic w_mst_stb;
   logic w_wd_count;
   logic w_wd_clear;
   logic w_expired;

   assign w_im_req = im_cyc_i & im_stb_i;
   assign w_dm_req = dm_cyc_i & dm_stb_i;
   assign w_sel_i  = (r_state == ST_GNT_I);
   assign w_sel_d  = (r_state == ST_GNT_D);

   // A master dropping cyc while granted aborts: nothing reaches the slave that cycle.
   assign w_mst_cyc = (w_sel_i & im_cyc_i) | (w_sel_d & dm_cyc_i);
   assign w_mst_stb = (w_sel_i & im_cyc_i & im_stb_i) | (w_sel_d & dm_cyc_i & dm_stb_i);

   assign w_wd_count = w_mst_stb & ~wb_ack_i & ~wb_err_i;
   assign w_wd_clear = (r_state == ST_IDLE) | wb_ack_i | wb_err_i;

   wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (w_wd_clear),
      .count_i   (w_wd_count),
      .expired_o (w_expired)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_last_gnt <= LAST_D;
      end else begin
         r_state    <= w_state_next;
         r_last_gnt <= w_last_gnt_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_last_gnt_next = r_last_gnt;
      case (r_state)
         ST_IDLE:
            w_state_next = arb_pick(w_im_req, w_dm_req, r_last_gnt, DATA_PRIORITY != 0);
         ST_GNT_I:
            if (!im_cyc_i || w_expired) begin
               w_state_next    = ST_IDLE;
               w_last_gnt_next = LAST_I;
            end
         ST_GNT_D:
            if (!dm_cyc_i || w_expired) begin
               w_state_next    = ST_IDLE;
               w_last_gnt_next = LAST_D;
            end
         default:
            w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      im_dat_o = '0;
      im_ack_o = 1'b0;
      im_err_o = 1'b0;
      dm_dat_o = '0;
      dm_ack_o = 1'b0;
      dm_err_o = 1'b0;
      wb_adr_o = '0;
      wb_dat_o = '0;
      wb_sel_o = '0;
      wb_we_o  = 1'b0;
      wb_cyc_o = 1'b0;
      wb_stb_o = 1'b0;
      gnt_o    = GNT_NONE;
      if (!rst_i) begin
         if (w_sel_i) begin
            wb_adr_o = im_adr_i;
            wb_sel_o = im_sel_i;
         end else if (w_sel_d) begin
            wb_adr_o = dm_adr_i;
            wb_dat_o = dm_dat_i;
            wb_sel_o = dm_sel_i;
            wb_we_o  = dm_we_i;
         end
         // An expiring cycle is withdrawn from the slave and failed back to the master.
         wb_cyc_o = w_mst_cyc & ~w_expired;
         wb_stb_o = w_mst_stb & ~w_expired;
         gnt_o    = {w_sel_d, w_sel_i};
         if (w_sel_i || w_sel_d) begin
            im_dat_o = wb_dat_i;
            dm_dat_o = wb_dat_i;
         end
         im_ack_o = w_sel_i & w_mst_cyc & wb_ack_i;
         im_err_o = w_sel_i & w_mst_cyc & (wb_err_i | w_expired);
         dm_ack_o = w_sel_d & w_mst_cyc & wb_ack_i;
         dm_err_o = w_sel_d & w_mst_cyc & (wb_err_i | w_expired);
      end
   end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: a response scoreboard checks every ack/err seen by the
// masters, and grant/bus outputs are compared against hand-computed values per cycle.
module tb_cpu_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i;
   logic [31:0] im_adr;
   logic [1:0]  im_sel;
   logic        im_cyc, im_stb;
   logic [31:0] dm_adr;
   logic [15:0] dm_dat;
   logic [1:0]  dm_sel;
   logic        dm_we, dm_cyc, dm_stb;
   logic [15:0] wb_dat_in;
   logic        wb_ack, wb_err;

   logic [15:0] a_im_dat, a_dm_dat, a_wb_dat;
   logic        a_im_ack, a_im_err, a_dm_ack, a_dm_err;
   logic [31:0] a_wb_adr;
   logic [1:0]  a_wb_sel, a_gnt;
   logic        a_wb_we, a_wb_cyc, a_wb_stb;

   logic [15:0] b_im_dat, b_dm_dat, b_wb_dat;
   logic        b_im_ack, b_im_err, b_dm_ack, b_dm_err;
   logic [31:0] b_wb_adr;
   logic [1:0]  b_wb_sel, b_gnt;
   logic        b_wb_we, b_wb_cyc, b_wb_stb;

   cpu_mem_arbiter #(.TIMEOUT(8), .DATA_PRIORITY(1)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .im_adr_i(im_adr), .im_sel_i(im_sel), .im_cyc_i(im_cyc), .im_stb_i(im_stb),
      .im_dat_o(a_im_dat), .im_ack_o(a_im_ack), .im_err_o(a_im_err),
      .dm_adr_i(dm_adr), .dm_dat_i(dm_dat), .dm_sel_i(dm_sel), .dm_we_i(dm_we),
      .dm_cyc_i(dm_cyc), .dm_stb_i(dm_stb),
      .dm_dat_o(a_dm_dat), .dm_ack_o(a_dm_ack), .dm_err_o(a_dm_err),
      .wb_adr_o(a_wb_adr), .wb_dat_o(a_wb_dat), .wb_sel_o(a_wb_sel), .wb_we_o(a_wb_we),
      .wb_cyc_o(a_wb_cyc), .wb_stb_o(a_wb_stb),
      .wb_dat_i(wb_dat_in), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
      .gnt_o(a_gnt)
   );

   cpu_mem_arbiter #(.TIMEOUT(255), .DATA_PRIORITY(0)) dut_rr (
      .clk_i(clk), .rst_i(rst_i),
      .im_adr_i(im_adr), .im_sel_i(im_sel), .im_cyc_i(im_cyc), .im_stb_i(im_stb),
      .im_dat_o(b_im_dat), .im_ack_o(b_im_ack), .im_err_o(b_im_err),
      .dm_adr_i(dm_adr), .dm_dat_i(dm_dat), .dm_sel_i(dm_sel), .dm_we_i(dm_we),
      .dm_cyc_i(dm_cyc), .dm_stb_i(dm_stb),
      .dm_dat_o(b_dm_dat), .dm_ack_o(b_dm_ack), .dm_err_o(b_dm_err),
      .wb_adr_o(b_wb_adr), .wb_dat_o(b_wb_dat), .wb_sel_o(b_wb_sel), .wb_we_o(b_wb_we),
      .wb_cyc_o(b_wb_cyc), .wb_stb_o(b_wb_stb),
      .wb_dat_i(wb_dat_in), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
      .gnt_o(b_gnt)
   );

   // Response flags in the order {im_ack, im_err, dm_ack, dm_err}.
   localparam logic [3:0] R_IM_ACK = 4'b1000;
   localparam logic [3:0] R_IM_ERR = 4'b0100;
   localparam logic [3:0] R_DM_ACK = 4'b0010;
   localparam logic [3:0] R_DM_ERR = 4'b0001;

   typedef struct packed {
      logic [3:0]  flags;
      logic [15:0] dat;
   } resp_t;

   resp_t sb_q[$];
   int    n_vec  = 0;
   int    n_miss = 0;
   bit    sb_en  = 1'b1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, got);
      end
   endtask

   task automatic expect_resp(input logic [3:0] f, input logic [15:0] d);
      sb_q.push_back('{flags: f, dat: d});
   endtask

   // Monitor: every master-side ack/err must match the oldest expected response.
   logic [3:0]  mon_got;
   logic [15:0] mon_dat;
   resp_t       mon_exp;
   always @(negedge clk) begin
      if (sb_en) begin
         mon_got = {a_im_ack, a_im_err, a_dm_ack, a_dm_err};
         if (mon_got != 4'b0000) begin
            n_vec++;
            mon_dat = (mon_got[3] || mon_got[2]) ? a_im_dat : a_dm_dat;
            if (sb_q.size() == 0) begin
               n_miss++;
               $display("FAIL resp_unexpected: got flags=%b dat=0x%0h expected none", mon_got, mon_dat);
            end else begin
               mon_exp = sb_q.pop_front();
               if (mon_got !== mon_exp.flags || mon_dat !== mon_exp.dat) begin
                  n_miss++;
                  $display("FAIL resp: got flags=%b dat=0x%0h expected flags=%b dat=0x%0h",
                           mon_got, mon_dat, mon_exp.flags, mon_exp.dat);
               end else begin
                  $display("ok   resp: flags=%b dat=0x%0h", mon_got, mon_dat);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: bench did not complete within time limit");
      $fatal(1, "timeout");
   end

   logic [1:0] exp_rr [4];
   logic [1:0] g;
   int         waited;

   initial begin
      rst_i = 1'b1;
      im_adr = '0; im_sel = '0; im_cyc = 1'b0; im_stb = 1'b0;
      dm_adr = '0; dm_dat = '0; dm_sel = '0; dm_we = 1'b0; dm_cyc = 1'b0; dm_stb = 1'b0;
      wb_dat_in = '0; wb_ack = 1'b0; wb_err = 1'b0;
      exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;

      // Reset: outputs held low even with a master requesting
      repeat (3) tick;
      im_cyc = 1'b1; im_stb = 1'b1;
      @(negedge clk);
      chk("rst_gnt", 32'(a_gnt), 32'd0);
      chk("rst_wb_cyc_stb", 32'({a_wb_cyc, a_wb_stb}), 32'd0);
      tick;
      rst_i = 1'b0; im_cyc = 1'b0; im_stb = 1'b0;
      @(negedge clk);
      chk("post_rst_outs", 32'({a_gnt, a_wb_cyc, a_wb_stb, a_wb_we, a_im_ack, a_dm_ack}), 32'd0);

      // I-only read, slave acks after 3 wait cycles
      tick;
      im_adr = 32'h1000; im_sel = 2'b11; im_cyc = 1'b1; im_stb = 1'b1;
      @(negedge clk);
      chk("t1_gnt_req_cycle", 32'(a_gnt), 32'd0);
      tick;
      @(negedge clk);
      chk("t1_gnt_next", 32'(a_gnt), 32'd1);
      chk("t1_wb_adr", a_wb_adr, 32'h1000);
      chk("t1_wb_cyc_stb_we", 32'({a_wb_cyc, a_wb_stb, a_wb_we}), 32'd6);
      tick; tick;
      tick;
      wb_ack = 1'b1; wb_dat_in = 16'h2A01;
      expect_resp(R_IM_ACK, 16'h2A01);
      tick;
      wb_ack = 1'b0; wb_dat_in = '0; im_cyc = 1'b0; im_stb = 1'b0;
      tick;
      @(negedge clk);
      chk("t1_idle", 32'(a_gnt), 32'd0);

      // Both request together: data first, one IDLE cycle, then instruction
      tick;
      im_adr = 32'h1100; im_cyc = 1'b1; im_stb = 1'b1;
      dm_adr = 32'h2000; dm_dat = 16'hBEEF; dm_sel = 2'b11; dm_we = 1'b1;
      dm_cyc = 1'b1; dm_stb = 1'b1;
      tick;
      @(negedge clk);
      chk("t2_gnt_d_first", 32'(a_gnt), 32'd2);
      chk("t2_wb_adr", a_wb_adr, 32'h2000);
      chk("t2_wb_we_dat", 32'({a_wb_we, a_wb_dat}), 32'h1BEEF);
      tick;
      wb_ack = 1'b1;
      expect_resp(R_DM_ACK, 16'h0000);
      tick;
      wb_ack = 1'b0; dm_cyc = 1'b0; dm_stb = 1'b0; dm_we = 1'b0;
      tick;
      @(negedge clk);
      chk("t2_idle_gap", 32'(a_gnt), 32'd0);
      tick;
      @(negedge clk);
      chk("t2_gnt_i_after", 32'(a_gnt), 32'd1);
      chk("t2_wb_we_zero", 32'(a_wb_we), 32'd0);
      tick;
      wb_err = 1'b1;
      expect_resp(R_IM_ERR, 16'h0000);
      tick;
      wb_err = 1'b0;
      @(negedge clk);
      chk("t2_err_grant_kept", 32'(a_gnt), 32'd1);
      tick;
      wb_ack = 1'b1; wb_dat_in = 16'h1234;
      expect_resp(R_IM_ACK, 16'h1234);
      tick;
      wb_ack = 1'b0; wb_dat_in = '0; im_cyc = 1'b0; im_stb = 1'b0;
      tick; tick;

      // 4-beat refill with strobe gaps while data master waits
      tick;
      im_adr = 32'h4000; im_cyc = 1'b1; im_stb = 1'b1;
      tick;
      dm_adr = 32'h6000; dm_we = 1'b0; dm_cyc = 1'b1; dm_stb = 1'b1;
      for (int b = 0; b < 4; b++) begin
         im_stb = 1'b1; im_adr = 32'h4000 + 32'(2 * b);
         wb_ack = 1'b1; wb_dat_in = 16'(16'h3000 + b);
         expect_resp(R_IM_ACK, 16'(16'h3000 + b));
         @(negedge clk);
         chk("t3_gnt_beat", 32'(a_gnt), 32'd1);
         tick;
         wb_ack = 1'b0; wb_dat_in = '0; im_stb = 1'b0;
         if (b < 3) begin
            @(negedge clk);
            chk("t3_gnt_gap", 32'(a_gnt), 32'd1);
            tick;
         end
      end
      im_cyc = 1'b0;
      tick;
      @(negedge clk);
      chk("t3_idle", 32'(a_gnt), 32'd0);
      tick;
      @(negedge clk);
      chk("t3_gnt_d_after", 32'(a_gnt), 32'd2);
      tick;
      wb_ack = 1'b1; wb_dat_in = 16'h5555;
      expect_resp(R_DM_ACK, 16'h5555);
      tick;
      wb_ack = 1'b0; wb_dat_in = '0; dm_cyc = 1'b0; dm_stb = 1'b0;
      tick; tick;

      // Watchdog: data write never acked, fails on the 8th strobed cycle
      tick;
      dm_adr = 32'h7000; dm_dat = 16'hCAFE; dm_we = 1'b1; dm_cyc = 1'b1; dm_stb = 1'b1;
      expect_resp(R_DM_ERR, 16'h0000);
      for (int i = 1; i <= 8; i++) begin
         tick;
         @(negedge clk);
         chk("t4_err_timing", 32'(a_dm_err), 32'(i == 8));
         if (i == 7) chk("t4_cyc_before", 32'({a_wb_cyc, a_wb_stb}), 32'd3);
         if (i == 8) chk("t4_cyc_forced", 32'({a_wb_cyc, a_wb_stb, a_gnt}), 32'd2);
      end
      tick;
      dm_cyc = 1'b0; dm_stb = 1'b0; dm_we = 1'b0;
      @(negedge clk);
      chk("t4_idle", 32'(a_gnt), 32'd0);

      // Ack arriving on the expiring cycle wins over the timeout
      tick;
      dm_adr = 32'h7100; dm_cyc = 1'b1; dm_stb = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick;
         if (i == 8) begin
            wb_ack = 1'b1; wb_dat_in = 16'h00AB;
            expect_resp(R_DM_ACK, 16'h00AB);
            @(negedge clk);
            chk("t4b_cyc_kept", 32'(a_wb_cyc), 32'd1);
         end
      end
      tick;
      wb_ack = 1'b0; wb_dat_in = '0; dm_cyc = 1'b0; dm_stb = 1'b0;
      tick; tick;

      // Reset in the middle of an instruction cycle with ack pending
      tick;
      im_adr = 32'h8000; im_cyc = 1'b1; im_stb = 1'b1;
      tick;
      @(negedge clk);
      chk("t5_gnt_before", 32'(a_gnt), 32'd1);
      tick;
      rst_i = 1'b1; wb_ack = 1'b1; wb_dat_in = 16'h7777;
      @(negedge clk);
      chk("t5_rst_gnt", 32'(a_gnt), 32'd0);
      chk("t5_rst_ack_err", 32'({a_im_ack, a_im_err, a_wb_cyc}), 32'd0);
      tick;
      rst_i = 1'b0; wb_ack = 1'b0; wb_dat_in = '0;
      @(negedge clk);
      chk("t5_post_rst_idle", 32'(a_gnt), 32'd0);
      tick;
      @(negedge clk);
      chk("t5_regrant", 32'(a_gnt), 32'd1);
      tick;
      wb_ack = 1'b1; wb_dat_in = 16'h0F0F;
      expect_resp(R_IM_ACK, 16'h0F0F);
      tick;
      wb_ack = 1'b0; wb_dat_in = '0; im_cyc = 1'b0; im_stb = 1'b0;
      tick; tick;
      chk("sb_drain", 32'(sb_q.size()), 32'd0);

      // Round-robin instance: continuous dual requests alternate starting with I
      sb_en = 1'b0;
      rst_i = 1'b1;
      tick; tick;
      rst_i = 1'b0;
      im_cyc = 1'b1; im_stb = 1'b1; dm_cyc = 1'b1; dm_stb = 1'b1; dm_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
         g = 2'b00;
         waited = 0;
         while (waited < 6) begin
            @(negedge clk);
            g = b_gnt;
            if (g != 2'b00) break;
            waited++;
         end
         chk("rr_grant", 32'(g), 32'(exp_rr[k]));
         tick;
         if (g[0]) im_cyc = 1'b0;
         if (g[1]) dm_cyc = 1'b0;
         tick;
         im_cyc = 1'b1; dm_cyc = 1'b1;
      end
      im_cyc = 1'b0; im_stb = 1'b0; dm_cyc = 1'b0; dm_stb = 1'b0;
      tick; tick;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
